// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin front-end for the 256x16 dual-port memory.
// Serialises one read or write at a time and returns read data to its issuer.
module mem_req_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          busy,
    output logic          mem_we_a,
    output logic          mem_we_b,
    output logic          mem_port_sel,
    output logic [AW-1:0] mem_addr_wa,
    output logic [AW-1:0] mem_addr_wb,
    output logic [DW-1:0] mem_data_wa,
    output logic [DW-1:0] mem_data_wb,
    input  logic [DW-1:0] mem_data_q
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    logic [1:0] state, state_nx;
    logic       last_grant;  // 0=A, 1=B
    logic       owner;
    logic       is_rd;
    logic [1:0] cnt;
    logic       any_req;
    logic       pick_b;

    // B wins when it is the only requester, or on a tie when A was served last.
    always_comb begin
        any_req = a_req | b_req;
        pick_b  = b_req & (~a_req | ~last_grant);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = ISSUE;
            ISSUE:   if (is_rd) state_nx = (RD_LAT == 0) ? RESP : RDWAIT;
                     else       state_nx = IDLE;
            RDWAIT:  if (cnt == LAT_LAST) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            is_rd        <= 1'b0;
            cnt          <= 2'd0;
            busy         <= 1'b0;
            a_gnt        <= 1'b0;
            b_gnt        <= 1'b0;
            a_rvalid     <= 1'b0;
            b_rvalid     <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
            mem_we_a     <= 1'b0;
            mem_we_b     <= 1'b0;
            mem_port_sel <= 1'b0;
            mem_addr_wa  <= '0;
            mem_addr_wb  <= '0;
            mem_data_wa  <= '0;
            mem_data_wb  <= '0;
        end else begin
            // Single-cycle pulses; memory pins other than the write enables hold.
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            mem_we_a <= 1'b0;
            mem_we_b <= 1'b0;
            state    <= state_nx;
            busy     <= (state_nx != IDLE);

            if (state == IDLE && any_req) begin
                owner      <= pick_b;
                last_grant <= pick_b;
                cnt        <= 2'd0;
                if (pick_b) begin
                    is_rd        <= ~b_we;
                    b_gnt        <= 1'b1;
                    mem_port_sel <= 1'b1;
                    mem_addr_wb  <= b_addr;
                    mem_data_wb  <= b_wdata;
                    mem_we_b     <= b_we;
                end else begin
                    is_rd        <= ~a_we;
                    a_gnt        <= 1'b1;
                    mem_port_sel <= 1'b0;
                    mem_addr_wa  <= a_addr;
                    mem_data_wa  <= a_wdata;
                    mem_we_a     <= a_we;
                end
            end

            if (state == RDWAIT) cnt <= cnt + 2'd1;

            // The edge entering RESP is where memory read data is valid.
            if (state != RESP && state_nx == RESP) begin
                if (owner) begin
                    b_rvalid <= 1'b1;
                    b_rdata  <= mem_data_q;
                end else begin
                    a_rvalid <= 1'b1;
                    a_rdata  <= mem_data_q;
                end
            end
        end
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Request front-end that sits directly upstream of the 256x16 dual-port memory (mem_256x16).
- Accepts read/write transactions from two requesters (A, B) on a req/gnt/rvalid handshake.
- Arbitrates round-robin and drives the memory's we_a/we_b/port_sel/addr/data pins, one transaction at a time.
- Captures read data from data_q and returns it to the requester that issued the read.

Parameters:
- AW, 8, address width (matches 256-word memory)
- DW, 16, data width
- RD_LAT, 1, cycles from memory address presentation to valid data_q (legal range 0..3)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- a_req  input  1  requester A transaction request, held until a_gnt
- a_we  input  1  A: 1=write, 0=read
- a_addr  input  AW  A address
- a_wdata  input  DW  A write data
- a_gnt  output  1  one-cycle pulse: A request accepted
- a_rvalid  output  1  one-cycle pulse: a_rdata valid
- a_rdata  output  DW  A read data, held until next A read completes
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B
- busy  output  1  high whenever FSM not IDLE
- mem_we_a  output  1  to memory we_a
- mem_we_b  output  1  to memory we_b
- mem_port_sel  output  1  to memory port_sel (0=A, 1=B)
- mem_addr_wa  output  AW  to memory addr_wa
- mem_addr_wb  output  AW  to memory addr_wb
- mem_data_wa  output  DW  to memory data_wa
- mem_data_wb  output  DW  to memory data_wb
- mem_data_q  input  DW  from memory data_q

Behaviour:
- Reset (rst_n=0, async): all outputs 0; FSM=IDLE; last_grant=B, so A wins the first tie; read-wait counter=0.
- All outputs registered.
- FSM states: IDLE, ISSUE, RDWAIT, RESP.
- IDLE:
  - Requests are sampled only here.
  - If only one req is high, that requester wins. If both are high, the one not in last_grant wins.
  - On the edge: state->ISSUE; winner's gnt=1 for the next cycle; last_grant updated.
  - Winner's fields are loaded: A -> mem_addr_wa/mem_data_wa with mem_port_sel=0; B -> mem_addr_wb/mem_data_wb with mem_port_sel=1.
  - No req: stay, all pulses 0.
- ISSUE (exactly 1 cycle):
  - Write: winner's mem_we_x=1 for this cycle only; next state IDLE.
  - Read: mem_we_* stay 0; next state RDWAIT, or RESP if RD_LAT=0.
- RDWAIT: counts RD_LAT cycles after ISSUE, then goes to RESP. The RESP entry edge samples mem_data_q.
  - RD_LAT=0: sample at end of ISSUE.
  - RD_LAT=1: sample at end of first RDWAIT cycle.
- RESP (1 cycle): owner's x_rvalid=1 with x_rdata = sampled value; next state IDLE.
- Latency (RD_LAT=1), req seen in cycle 0:
  - gnt in cycle 1.
  - Write: memory writes at end of cycle 1; throughput 1 write per 2 cycles.
  - Read: rvalid in cycle 3.
- Memory-pin retention:
  - mem_we_a/mem_we_b are never both high and are 0 outside ISSUE.
  - mem_port_sel, addresses and write data hold their last values between transactions (no glitch to 0).
- Requests during busy (FSM not IDLE) are ignored: no gnt, no queueing. Requester keeps req high.
- A req dropped before gnt has no effect.
- A requester may raise req again in the cycle after its gnt; it is serviced once the FSM is back in IDLE.
- Fairness: with both reqs continuously high, grants strictly alternate A,B,A,B.
- No address range checking (full AW space valid).
- Reset mid-read: pending read discarded, no rvalid issued, rdata cleared to 0.
- x_rdata is unchanged by writes and by the other requester's reads.

Test Plan:
- Reset then A write 0x00=0xAAAA, 0x01=0x5555, 0x02=0x1234, 0x03=0xABCD -> a_gnt pulse each, mem_we_a high one cycle each, mem_port_sel=0, mem_we_b=0 throughout.
- A reads 0x00..0x03 (RD_LAT=1) -> a_rvalid 3 cycles after req sampled, a_rdata=0xAAAA, 0x5555, 0x1234, 0xABCD; no b_rvalid.
- B writes 0x14=0xDEAD, 0x15=0xBEEF, then B reads 0x15 -> mem_port_sel=1, mem_we_b pulses, b_rdata=0xBEEF; a_rdata still 0xABCD.
- a_req and b_req held high together for 4 reads -> grant order A,B,A,B; each rvalid goes to the correct port with correct data; busy high between IDLE visits.
- b_req raised while A read is in RDWAIT -> no b_gnt until after a_rvalid; B granted in the IDLE cycle that follows.
- rst_n pulsed low during RDWAIT of an A read -> all outputs 0 immediately, no a_rvalid; next A read of 0x02 returns 0x1234.
